// File: rtl/decode_pkg.sv
// Shared definitions for the decode stage: instruction field offsets, the
// decoded-instruction record and the immediate sign-extension helper.
package decode_pkg;

    localparam int DEF_REG_AW = 6;
    localparam int DEF_OP_W   = 4;
    localparam int DEF_IMMF_W = 9;
    localparam int DEF_IMM_W  = 16;

    // Fields from LSB upward: imm, rt, alu_op, rd, rs, then the mux_sel bit.
    function automatic int rt_lsb(input int immf_w);
        return immf_w;
    endfunction

    function automatic int op_lsb(input int reg_aw, input int immf_w);
        return immf_w + reg_aw;
    endfunction

    function automatic int rd_lsb(input int reg_aw, input int op_w, input int immf_w);
        return immf_w + reg_aw + op_w;
    endfunction

    function automatic int rs_lsb(input int reg_aw, input int op_w, input int immf_w);
        return immf_w + 2 * reg_aw + op_w;
    endfunction

    typedef struct packed {
        logic                  mux_sel;
        logic [DEF_REG_AW-1:0] rs;
        logic [DEF_REG_AW-1:0] rd;
        logic [DEF_OP_W-1:0]   alu_op;
        logic [DEF_REG_AW-1:0] rt;
        logic [DEF_IMM_W-1:0]  imm;
        logic                  reg_write;
    } decoded_t;

    // Replicates bit fw-1 of a zero-extended field into every higher bit.
    function automatic logic [63:0] sign_extend(input logic [63:0] field, input int fw);
        logic [63:0] r;
        logic [5:0]  msb;
        msb = 6'(fw - 1);
        r   = field;
        for (int i = 0; i < 64; i++) begin
            if (i >= fw) r[i] = field[msb];
        end
        return r;
    endfunction

endpackage

// File: rtl/decode_stage_scoreboard.sv
// Per-register pending-write tracker with a three-address busy query; a
// writeback in the current cycle already frees its register for the query.
module reg_scoreboard #(
    parameter int REG_AW = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_en,
    input  logic [REG_AW-1:0] set_addr,
    input  logic              clr_en,
    input  logic [REG_AW-1:0] clr_addr,
    input  logic [REG_AW-1:0] q_rs,
    input  logic [REG_AW-1:0] q_rt,
    input  logic [REG_AW-1:0] q_rd,
    output logic              busy_rs,
    output logic              busy_rt,
    output logic              busy_rd
);
    localparam int NREG = 2 ** REG_AW;

    logic [NREG-1:0] pending_q;
    logic [NREG-1:0] pending_d;

    // Set is applied after clear so a same-cycle issue to that register wins.
    always_comb begin
        pending_d = pending_q;
        if (clr_en) pending_d[clr_addr] = 1'b0;
        if (set_en) pending_d[set_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending_q <= '0;
        else        pending_q <= pending_d;
    end

    assign busy_rs = pending_q[q_rs] && !(clr_en && clr_addr == q_rs);
    assign busy_rt = pending_q[q_rt] && !(clr_en && clr_addr == q_rt);
    assign busy_rd = pending_q[q_rd] && !(clr_en && clr_addr == q_rd);

endmodule

// File: rtl/decode_stage.sv
// Registered instruction decode with valid/ready on both sides and a
// register scoreboard that holds off RAW/WAW hazards at the input.
module decode_stage
    import decode_pkg::*;
#(
    parameter int REG_AW = 6,
    parameter int OP_W   = 4,
    parameter int IMMF_W = 9,
    parameter int IMM_W  = 16,
    localparam int INST_W = 1 + 3 * REG_AW + OP_W + IMMF_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] in_inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_mux_sel,
    output logic [REG_AW-1:0] out_rs,
    output logic [REG_AW-1:0] out_rd,
    output logic [REG_AW-1:0] out_rt,
    output logic [OP_W-1:0]   out_alu_op,
    output logic [IMM_W-1:0]  out_imm,
    output logic              out_reg_write,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              flush
);
    localparam int RT_LSB  = rt_lsb(IMMF_W);
    localparam int OP_LSB  = op_lsb(REG_AW, IMMF_W);
    localparam int RD_LSB  = rd_lsb(REG_AW, OP_W, IMMF_W);
    localparam int RS_LSB  = rs_lsb(REG_AW, OP_W, IMMF_W);
    localparam int MUX_BIT = RS_LSB + REG_AW;

    logic              d_mux_sel;
    logic [REG_AW-1:0] d_rs;
    logic [REG_AW-1:0] d_rd;
    logic [REG_AW-1:0] d_rt;
    logic [OP_W-1:0]   d_alu_op;
    logic [IMM_W-1:0]  d_imm;
    logic              d_reg_write;

    assign d_mux_sel   = in_inst[MUX_BIT];
    assign d_rs        = in_inst[RS_LSB +: REG_AW];
    assign d_rd        = in_inst[RD_LSB +: REG_AW];
    assign d_alu_op    = in_inst[OP_LSB +: OP_W];
    assign d_rt        = in_inst[RT_LSB +: REG_AW];
    assign d_imm       = IMM_W'(sign_extend(64'(in_inst[IMMF_W-1:0]), IMMF_W));
    assign d_reg_write = (d_alu_op != '0);

    logic issue;
    logic accept;
    logic hazard;
    logic sb_rs, sb_rt, sb_rd;
    logic busy_rs, busy_rt, busy_rd;

    assign issue = out_valid && out_ready && !flush;

    reg_scoreboard #(.REG_AW(REG_AW)) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (issue && out_reg_write),
        .set_addr (out_rd),
        .clr_en   (wb_valid),
        .clr_addr (wb_rd),
        .q_rs     (d_rs),
        .q_rt     (d_rt),
        .q_rd     (d_rd),
        .busy_rs  (sb_rs),
        .busy_rt  (sb_rt),
        .busy_rd  (sb_rd)
    );

    // The held writer is not pending yet, so it is matched here directly.
    assign busy_rs = sb_rs || (out_valid && out_reg_write && out_rd == d_rs);
    assign busy_rt = sb_rt || (out_valid && out_reg_write && out_rd == d_rt);
    assign busy_rd = sb_rd || (out_valid && out_reg_write && out_rd == d_rd);

    assign hazard   = busy_rs || (!d_mux_sel && busy_rt) || (d_reg_write && busy_rd);
    assign in_ready = !flush && !hazard && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_mux_sel   <= 1'b0;
            out_rs        <= '0;
            out_rd        <= '0;
            out_rt        <= '0;
            out_alu_op    <= '0;
            out_imm       <= '0;
            out_reg_write <= 1'b0;
        end else begin
            if (flush)      out_valid <= 1'b0;
            else if (accept) out_valid <= 1'b1;
            else if (issue)  out_valid <= 1'b0;

            if (accept) begin
                out_mux_sel   <= d_mux_sel;
                out_rs        <= d_rs;
                out_rd        <= d_rd;
                out_rt        <= d_rt;
                out_alu_op    <= d_alu_op;
                out_imm       <= d_imm;
                out_reg_write <= d_reg_write;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed hazard/flush/reset scenarios plus a short
// random stream, with decoded outputs checked against an expected queue.
module tb_decode_stage;
    import decode_pkg::*;

    localparam int REG_AW = 6;
    localparam int OP_W   = 4;
    localparam int IMMF_W = 9;
    localparam int IMM_W  = 16;
    localparam int INST_W = 32;
    localparam int W      = $bits(decoded_t);

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [INST_W-1:0] in_inst;
    logic              out_valid;
    logic              out_ready;
    logic              out_mux_sel;
    logic [REG_AW-1:0] out_rs, out_rd, out_rt;
    logic [OP_W-1:0]   out_alu_op;
    logic [IMM_W-1:0]  out_imm;
    logic              out_reg_write;
    logic              wb_valid;
    logic [REG_AW-1:0] wb_rd;
    logic              flush;

    int checks = 0;
    int errors = 0;
    bit rnd_ready = 0;
    logic [W-1:0] exp_q[$];

    decode_stage #(.REG_AW(REG_AW), .OP_W(OP_W), .IMMF_W(IMMF_W), .IMM_W(IMM_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_inst      (in_inst),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_mux_sel  (out_mux_sel),
        .out_rs       (out_rs),
        .out_rd       (out_rd),
        .out_rt       (out_rt),
        .out_alu_op   (out_alu_op),
        .out_imm      (out_imm),
        .out_reg_write(out_reg_write),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .flush        (flush)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic decoded_t model(input logic [31:0] i);
        decoded_t d;
        d.mux_sel   = i[31];
        d.rs        = i[30:25];
        d.rd        = i[24:19];
        d.alu_op    = i[18:15];
        d.rt        = i[14:9];
        d.imm       = {{7{i[8]}}, i[8:0]};
        d.reg_write = (i[18:15] != 4'd0);
        return d;
    endfunction

    function automatic logic [31:0] make_inst(input logic mux, input logic [5:0] rs,
        input logic [5:0] rd, input logic [3:0] op, input logic [5:0] rt, input logic [8:0] imm);
        return {mux, rs, rd, op, rt, imm};
    endfunction

    // scoreboard: pop on issue/flush, push on accept
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && (out_ready || flush)) begin
                if (exp_q.size() == 0) begin
                    check("out_without_exp", 64'(out_valid), 64'd0);
                end else begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    if (!flush)
                        check("out_data", 64'({out_mux_sel, out_rs, out_rd, out_alu_op,
                                               out_rt, out_imm, out_reg_write}), 64'(e));
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(in_inst));
        end
    end

    // driver: offer until accepted, bounded
    task automatic send(input logic [31:0] inst);
        bit done;
        done = 0;
        in_inst  = inst;
        in_valid = 1'b1;
        for (int n = 0; n < 64 && !done; n++) begin
            @(negedge clk);
            if (in_ready) done = 1;
            @(posedge clk);
            #1;
            if (rnd_ready && !done) out_ready = ($urandom_range(0, 3) != 0);
        end
        if (!done) check("accept_timeout", 64'(in_ready), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_inst = '0; out_ready = 1'b0;
        wb_valid = 1'b0; wb_rd = '0; flush = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_reg_write", 64'(out_reg_write), 64'd0);
        check("rst_out_data", 64'({out_rs, out_rd, out_rt, out_alu_op, out_imm}), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        cycle();

        // basic decode
        out_ready = 1'b1;
        send(32'h06290FF0);
        @(negedge clk);
        check("dec_valid", 64'(out_valid), 64'd1);
        check("dec_mux", 64'(out_mux_sel), 64'd0);
        check("dec_rs", 64'(out_rs), 64'd3);
        check("dec_rd", 64'(out_rd), 64'd5);
        check("dec_op", 64'(out_alu_op), 64'd2);
        check("dec_rt", 64'(out_rt), 64'd7);
        check("dec_imm", 64'(out_imm), 64'hFFF0);
        check("dec_we", 64'(out_reg_write), 64'd1);
        cycle();
        wb_valid = 1'b1; wb_rd = 6'd5;
        cycle();
        wb_valid = 1'b0;

        // non-writer sets no pending bit
        send(make_inst(1'b0, 6'd1, 6'd2, 4'd0, 6'd3, 9'h0F0));
        @(negedge clk);
        check("nw_we", 64'(out_reg_write), 64'd0);
        check("nw_imm", 64'(out_imm), 64'h00F0);
        cycle();
        in_inst = make_inst(1'b0, 6'd2, 6'd2, 4'd1, 6'd2, 9'd0);
        @(negedge clk);
        check("nw_no_pending", 64'(in_ready), 64'd1);
        cycle();

        // RAW stall released by same-cycle writeback
        send(make_inst(1'b0, 6'd1, 6'd5, 4'd2, 6'd2, 9'd0));
        in_inst  = make_inst(1'b0, 6'd5, 6'd6, 4'd0, 6'd1, 9'd4);
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("raw_stall", 64'(in_ready), 64'd0);
            cycle();
        end
        wb_valid = 1'b1; wb_rd = 6'd5;
        @(negedge clk);
        check("raw_wb_bypass", 64'(in_ready), 64'd1);
        cycle();
        in_valid = 1'b0; wb_valid = 1'b0;
        cycle();

        // rt ignored when mux_sel selects immediate
        send(make_inst(1'b0, 6'd1, 6'd9, 4'd3, 6'd1, 9'd0));
        cycle();
        in_inst = make_inst(1'b1, 6'd1, 6'd2, 4'd0, 6'd9, 9'd5);
        @(negedge clk);
        check("rt_ignored", 64'(in_ready), 64'd1);
        send(make_inst(1'b1, 6'd1, 6'd2, 4'd0, 6'd9, 9'd5));
        in_inst  = make_inst(1'b0, 6'd1, 6'd2, 4'd0, 6'd9, 9'd5);
        in_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("rt_stall", 64'(in_ready), 64'd0);
            cycle();
        end
        wb_valid = 1'b1; wb_rd = 6'd9;
        @(negedge clk);
        check("rt_wb_bypass", 64'(in_ready), 64'd1);
        cycle();
        in_valid = 1'b0; wb_valid = 1'b0;
        cycle();

        // backpressure then flush
        send(make_inst(1'b0, 6'd4, 6'd10, 4'd1, 6'd4, 9'h1AB));
        out_ready = 1'b0;
        in_inst   = make_inst(1'b1, 6'd11, 6'd12, 4'd0, 6'd11, 9'd0);
        in_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_rd", 64'(out_rd), 64'd10);
            check("bp_imm", 64'(out_imm), 64'hFFAB);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            cycle();
        end
        in_valid = 1'b0;
        flush    = 1'b1;
        cycle();
        flush = 1'b0;
        @(negedge clk);
        check("flush_valid", 64'(out_valid), 64'd0);
        cycle();
        out_ready = 1'b1;
        in_inst   = make_inst(1'b0, 6'd10, 6'd10, 4'd1, 6'd10, 9'd0);
        @(negedge clk);
        check("flush_no_pending", 64'(in_ready), 64'd1);
        cycle();

        // random non-writer stream with random backpressure
        rnd_ready = 1;
        for (int k = 0; k < 30; k++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            send(make_inst(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
                           6'($urandom_range(0, 63)), 4'd0, 6'($urandom_range(0, 63)),
                           9'($urandom_range(0, 511))));
        end
        rnd_ready = 0;
        out_ready = 1'b1;
        repeat (3) cycle();
        check("drain_q_empty", 64'(exp_q.size()), 64'd0);

        // reset mid-stream with three pending bits and a held writer
        send(make_inst(1'b0, 6'd30, 6'd20, 4'd1, 6'd30, 9'd0));
        send(make_inst(1'b0, 6'd30, 6'd21, 4'd1, 6'd30, 9'd0));
        send(make_inst(1'b0, 6'd30, 6'd22, 4'd1, 6'd30, 9'd0));
        send(make_inst(1'b0, 6'd30, 6'd23, 4'd1, 6'd30, 9'd0));
        out_ready = 1'b0;
        @(negedge clk);
        check("pre_rst_held", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_rd", 64'(out_rd), 64'd0);
        exp_q.delete();
        cycle();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int r = 20; r < 24; r++) begin
            in_inst = make_inst(1'b0, 6'(r), 6'(r), 4'd1, 6'(r), 9'd0);
            @(negedge clk);
            check("rst_not_busy", 64'(in_ready), 64'd1);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
